// File: rtl/counter_date.sv
// counter_date
//
// Calendar stage fed by the hour counter's day-carry. Keeps day-of-month,
// month and year offset (2000..2099), with month lengths and leap years
// handled. It also supports manual setting of each field in load mode and
// emits a one-cycle century-wrap pulse.
//
// Ports
//   clock          in   divided system clock, rising-edge active
//   reset_hour     in   asynchronous, active-high reset
//   enable_day     in   day-carry level from the hour counter; only its rising edge counts
//   load_date      in   load mode; suppresses calendar advance
//   setting_day    in   load mode: +1 day per clock while high
//   setting_month  in   load mode: +1 month per clock while high
//   setting_year   in   load mode: +1 year per clock while high
//   count_day      out  day of month 1..31 (registered)
//   count_month    out  month 1..12 (registered)
//   count_year     out  year offset 0..99 (registered)
//   days_in_month  out  length of the current month (combinational)
//   carry_year     out  one-cycle pulse on the 2099-12-31 -> 2000-01-01 rollover
module counter_date (
    input  logic       clock,
    input  logic       reset_hour,
    input  logic       enable_day,
    input  logic       load_date,
    input  logic       setting_day,
    input  logic       setting_month,
    input  logic       setting_year,
    output logic [4:0] count_day,
    output logic [3:0] count_month,
    output logic [6:0] count_year,
    output logic [4:0] days_in_month,
    output logic       carry_year
);

    logic [4:0] day_q,   day_d;
    logic [3:0] month_q, month_d;
    logic [6:0] year_q,  year_d;
    logic       carry_q, carry_d;
    logic       en_q;

    logic       day_tick;
    logic       day_bad, month_bad, year_bad;
    logic [3:0] month_n;
    logic [6:0] year_n;
    logic [4:0] len_n;

    // Only the low two year bits matter: year%4 is exact for 2000..2099.
    function automatic logic [4:0] month_len(input logic [3:0] m, input logic [1:0] y_lo);
        logic [4:0] len;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
            4'd2:                    len = (y_lo == 2'd0) ? 5'd29 : 5'd28;
            default:                 len = 5'd31;
        endcase
        return len;
    endfunction

    assign days_in_month = month_len(month_q, year_q[1:0]);

    // enable_day is a level that stays high for an hour; en_q tracks it in
    // every mode, so a level still high when load mode ends is not a new edge.
    assign day_tick = enable_day & ~en_q;

    assign day_bad   = (day_q == 5'd0) || (day_q > days_in_month);
    assign month_bad = (month_q == 4'd0) || (month_q > 4'd12);
    assign year_bad  = (year_q > 7'd99);

    // Load-mode candidates: month and year first, then the day is judged
    // against the length of the new month so it clamps (31 Jan -> 28/29 Feb).
    always_comb begin
        month_n = month_q;
        year_n  = year_q;
        if (setting_month) begin
            month_n = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
        end
        if (setting_year) begin
            year_n = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
        end
        len_n = month_len(month_n, year_n[1:0]);
    end

    always_comb begin
        day_d   = day_q;
        month_d = month_q;
        year_d  = year_q;
        carry_d = 1'b0;
        if (load_date) begin
            month_d = month_n;
            year_d  = year_n;
            if (setting_day) begin
                day_d = (day_q >= len_n) ? 5'd1 : day_q + 5'd1;
            end else begin
                day_d = (day_q > len_n) ? len_n : day_q;
            end
        end else if (day_bad || month_bad || year_bad) begin
            // Recover corrupted fields to their reset values; skip the advance.
            if (day_bad)   day_d   = 5'd1;
            if (month_bad) month_d = 4'd1;
            if (year_bad)  year_d  = 7'd0;
        end else if (day_tick) begin
            if (day_q < days_in_month) begin
                day_d = day_q + 5'd1;
            end else begin
                day_d = 5'd1;
                if (month_q == 4'd12) begin
                    month_d = 4'd1;
                    if (year_q == 7'd99) begin
                        year_d  = 7'd0;
                        carry_d = 1'b1;
                    end else begin
                        year_d = year_q + 7'd1;
                    end
                end else begin
                    month_d = month_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset_hour) begin
        if (reset_hour) begin
            day_q   <= 5'd1;
            month_q <= 4'd1;
            year_q  <= 7'd0;
            carry_q <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
            carry_q <= carry_d;
            en_q    <= enable_day;
        end
    end

    assign count_day   = day_q;
    assign count_month = month_q;
    assign count_year  = year_q;
    assign carry_year  = carry_q;

endmodule

// File: tb/tb_counter_date.sv
module tb_counter_date;

  logic       clock = 1'b0;
  logic       reset_hour;
  logic       enable_day;
  logic       load_date;
  logic       setting_day;
  logic       setting_month;
  logic       setting_year;
  logic [4:0] count_day;
  logic [3:0] count_month;
  logic [6:0] count_year;
  logic [4:0] days_in_month;
  logic       carry_year;

  int n_checks = 0;
  int n_fail   = 0;

  // reference date model
  int m_day, m_month, m_year, m_carry, m_en;

  counter_date dut (
    .clock         (clock),
    .reset_hour    (reset_hour),
    .enable_day    (enable_day),
    .load_date     (load_date),
    .setting_day   (setting_day),
    .setting_month (setting_month),
    .setting_year  (setting_year),
    .count_day     (count_day),
    .count_month   (count_month),
    .count_year    (count_year),
    .days_in_month (days_in_month),
    .carry_year    (carry_year)
  );

  // clock / reset
  always #5 clock = ~clock;

  // calendar arithmetic on a day ordinal counted from 2000-01-01
  function automatic int dim(int m, int y);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && (y % 4) == 0) return 29;
    return t[m-1];
  endfunction

  function automatic int year_len(int y);
    return ((y % 4) == 0) ? 366 : 365;
  endfunction

  function automatic int to_ord(int d, int m, int y);
    int o = 0;
    for (int yy = 0; yy < y; yy++) o += year_len(yy);
    for (int mm = 1; mm < m; mm++) o += dim(mm, y);
    return o + d - 1;
  endfunction

  task automatic from_ord(input int o, output int d, output int m, output int y);
    y = 0;
    while (o >= year_len(y)) begin
      o -= year_len(y);
      y++;
    end
    m = 1;
    while (o >= dim(m, y)) begin
      o -= dim(m, y);
      m++;
    end
    d = o + 1;
  endtask

  task automatic model_reset();
    m_day = 1; m_month = 1; m_year = 0; m_carry = 0; m_en = 0;
  endtask

  // one clock of the reference, using the inputs currently driven
  task automatic model_step();
    int tick, ord, len;
    tick    = (enable_day && !m_en) ? 1 : 0;
    m_en    = enable_day;
    m_carry = 0;
    if (load_date) begin
      if (setting_month) m_month = (m_month == 12) ? 1 : m_month + 1;
      if (setting_year)  m_year  = (m_year == 99) ? 0 : m_year + 1;
      len = dim(m_month, m_year);
      if (setting_day) m_day = (m_day >= len) ? 1 : m_day + 1;
      else if (m_day > len) m_day = len;
    end else if (tick != 0) begin
      ord = to_ord(m_day, m_month, m_year);
      if (ord == 36524) begin
        ord = 0;
        m_carry = 1;
      end else begin
        ord++;
      end
      from_ord(ord, m_day, m_month, m_year);
    end
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("day",   {27'd0, count_day},     m_day);
    check("month", {28'd0, count_month},   m_month);
    check("year",  {25'd0, count_year},    m_year);
    check("carry", {31'd0, carry_year},    m_carry);
    check("dim",   {27'd0, days_in_month}, dim(m_month, m_year));
  endtask

  task automatic check_date(input string tag, input int d, input int m, input int y, input int c);
    check({tag, ".day"},   {27'd0, count_day},   d);
    check({tag, ".month"}, {28'd0, count_month}, m);
    check({tag, ".year"},  {25'd0, count_year},  y);
    check({tag, ".carry"}, {31'd0, carry_year},  c);
  endtask

  // drivers
  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    check_model();
  endtask

  task automatic set_date(input int d, input int m, input int y);
    load_date = 1'b1;
    setting_day = 1'b0; setting_month = 1'b0; setting_year = 1'b0;
    setting_year = 1'b1;
    for (int i = 0; i < 100 && m_year != y; i++) cycle();
    setting_year = 1'b0;
    setting_month = 1'b1;
    for (int i = 0; i < 12 && m_month != m; i++) cycle();
    setting_month = 1'b0;
    setting_day = 1'b1;
    for (int i = 0; i < 32 && m_day != d; i++) cycle();
    setting_day = 1'b0;
    cycle();
    check_date("set", d, m, y, 0);
  endtask

  initial begin
    reset_hour = 1'b1;
    enable_day = 1'b0; load_date = 1'b0;
    setting_day = 1'b0; setting_month = 1'b0; setting_year = 1'b0;
    model_reset();
    #2;
    check_date("reset", 1, 1, 0, 0);
    check("reset.dim", {27'd0, days_in_month}, 31);
    @(negedge clock);
    reset_hour = 1'b0;
    cycle();

    // a long enable_day level gives exactly one advance
    enable_day = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    check_date("hold", 2, 1, 0, 0);
    enable_day = 1'b0;
    cycle();
    enable_day = 1'b1;
    cycle();
    check_date("rerise", 3, 1, 0, 0);
    enable_day = 1'b0;
    cycle();

    // February in a common year and in a leap year
    set_date(28, 2, 1);
    load_date = 1'b0; cycle();
    enable_day = 1'b1; cycle();
    check_date("feb01", 1, 3, 1, 0);
    enable_day = 1'b0; cycle();
    set_date(28, 2, 4);
    load_date = 1'b0; cycle();
    enable_day = 1'b1; cycle();
    check_date("feb04a", 29, 2, 4, 0);
    enable_day = 1'b0; cycle();
    enable_day = 1'b1; cycle();
    check_date("feb04b", 1, 3, 4, 0);
    enable_day = 1'b0; cycle();

    // century wrap
    set_date(31, 12, 99);
    load_date = 1'b0; cycle();
    enable_day = 1'b1; cycle();
    check_date("wrap", 1, 1, 0, 1);
    cycle();
    check_date("wrap_next", 1, 1, 0, 0);
    enable_day = 1'b0; cycle();

    // day clamp when setting month and year
    set_date(31, 1, 3);
    setting_month = 1'b1; cycle(); setting_month = 1'b0;
    check_date("clamp", 28, 2, 3, 0);
    setting_year = 1'b1; cycle(); setting_year = 1'b0;
    check_date("leapset", 28, 2, 4, 0);
    setting_day = 1'b1; cycle();
    check_date("day29", 29, 2, 4, 0);
    cycle(); setting_day = 1'b0;
    check_date("dayroll", 1, 2, 4, 0);

    // an edge seen during load mode is lost
    enable_day = 1'b1; cycle();
    load_date = 1'b0; cycle(); cycle();
    check_date("lost", 1, 2, 4, 0);
    enable_day = 1'b0; cycle();
    enable_day = 1'b1; cycle();
    check_date("fresh", 2, 2, 4, 0);
    enable_day = 1'b0; cycle();

    // asynchronous reset with a pending tick
    set_date(15, 7, 42);
    load_date = 1'b0; cycle();
    @(negedge clock);
    enable_day = 1'b1;
    #2;
    reset_hour = 1'b1;
    #1;
    model_reset();
    check_date("areset", 1, 1, 0, 0);
    @(posedge clock);
    #1;
    check_date("areset_edge", 1, 1, 0, 0);
    enable_day = 1'b0;
    reset_hour = 1'b0;
    cycle();
    check_date("post_reset", 1, 1, 0, 0);

    // randomized traffic against the reference
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) load_date = ~load_date;
      if ($urandom_range(0, 7) == 0) enable_day = ~enable_day;
      setting_day   = ($urandom_range(0, 3) == 0);
      setting_month = ($urandom_range(0, 5) == 0);
      setting_year  = ($urandom_range(0, 5) == 0);
      cycle();
    end
    load_date = 1'b0;
    setting_day = 1'b0; setting_month = 1'b0; setting_year = 1'b0;
    cycle();

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_date.md
# counter_date

Calendar stage directly downstream of the hour counter. It consumes the hour counter's day-carry and keeps day-of-month, month and year (2000–2099) with month lengths and leap years handled. It supports button-driven manual setting of each field in load mode and emits a one-cycle century-wrap pulse. It runs on the same divided (~3 Hz) clock as the time-of-day counters.

## Interface
- No parameters.
- clock  in  1  divided system clock; all state updates on rising edge
- reset_hour  in  1  asynchronous, active-high reset
- enable_day  in  1  day-carry level from hour counter (carry_hour); stays high for a whole hour period, so only its rising edge counts
- load_date  in  1  load mode; while high, calendar advance from enable_day is suppressed
- setting_day  in  1  in load mode, +1 day each clock while high
- setting_month  in  1  in load mode, +1 month each clock while high
- setting_year  in  1  in load mode, +1 year each clock while high
- count_day  out  5  day of month, 1..31, registered
- count_month  out  4  month, 1..12, registered
- count_year  out  7  year offset from 2000, 0..99, registered
- days_in_month  out  5  length of current count_month/count_year (28/29/30/31), combinational
- carry_year  out  1  one-cycle pulse on 2099-12-31 -> 2000-01-01 rollover, registered

## Operation
- Reset (async, immediate): count_day=1, count_month=1, count_year=0, carry_year=0, internal enable_day delay register en_q=0.
- en_q <= enable_day every clock, in all modes. day_tick = enable_day & ~en_q.
- Month length: Apr/Jun/Sep/Nov = 30; Feb = 29 if count_year[1:0]==0 else 28; others = 31. The year%4 rule is exact for 2000–2099.
- Run mode (load_date=0), on day_tick:
  - count_day < days_in_month: day+1.
  - Otherwise day=1, then month+1; if month was 12, month=1 and year+1.
  - If year was 99 and wrap occurs: year=0, carry_year=1 for that cycle.
- carry_year is 0 in every cycle not meeting the wrap condition.
- Load mode (load_date=1): day_tick is ignored and discarded, not queued. Fields are computed in this order in one cycle:
  - month_n = setting_month ? (month==12 ? 1 : month+1) : month
  - year_n = setting_year ? (year==99 ? 0 : year+1) : year. No carry_year in load mode.
  - len_n = length of (month_n, year_n).
  - day_n = setting_day ? (day>=len_n ? 1 : day+1) : min(day, len_n). This clamps, e.g. 31 Jan -> set month -> 29/28 Feb.
- Leaving load mode: no catch-up. An enable_day rising edge that occurred during load is lost. enable_day still high at exit does not produce a tick, because en_q already tracked it.
- Illegal-state recovery in run mode: any field out of range (day 0 or > days_in_month, month 0 or > 12, year > 99) is forced to its reset value on the next clock, and no advance happens that cycle.

## Timing
- Advance latency: the date changes on the first rising edge at which enable_day is sampled 1 with en_q=0. That is one clock after the hour counter's 23->00 edge.
- Each enable_day low->high transition produces exactly one advance, regardless of how long it stays high.
- Load increments: one step per clock while a setting input is high; there is no internal debounce or one-shot.
- days_in_month reflects the registered outputs with zero-cycle latency.
- carry_year is high for exactly one clock, coincident with outputs showing 2000-01-01.
- Reset asserted mid-operation clears all state within the same cycle. Deassertion is taken synchronously by the next edge.

## Test plan
- Reset then hold enable_day high 10 clocks -> exactly one advance: 1/1/00 -> 2/1/00; release and re-raise -> 3/1/00.
- Load 28-Feb-01 (year 1), one enable_day pulse -> 1-Mar-01; repeat from 28-Feb-04 -> 29-Feb-04, next pulse -> 1-Mar-04.
- Load 31-Dec-99, pulse enable_day -> 1-Jan-00 with carry_year=1 for exactly one clock, 0 the next clock.
- In load mode at 31-Jan-03, assert setting_month 1 clock -> 28-Feb-03; setting_year to 04 then setting_day 1 clock -> 29-Feb-04 then next clock 1-Feb-04.
- enable_day rises while load_date=1, then load_date drops while enable_day is still high -> no advance. Next fresh rising edge -> one advance.
- Assert reset_hour mid-clock at 15-Jul-42 with a pending tick -> outputs 1/1/00 immediately, carry_year=0, no advance on the next edge.
